// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller.
//   - FWD_* : ALU operand-forwarding select encodings driven to the ID stage
//   - hz_state_t : sequencing FSM states (normal flow / mul-div occupying EX)
package pipe_hazard_ctrl_pkg;

    localparam logic [1:0] FWD_REG    = 2'b00;  // operand from register file
    localparam logic [1:0] FWD_EXALU  = 2'b01;  // EX-stage ALU result
    localparam logic [1:0] FWD_MEMALU = 2'b10;  // MEM-stage ALU result
    localparam logic [1:0] FWD_MEMLD  = 2'b11;  // MEM-stage load data

    typedef enum logic {
        RUN     = 1'b0,
        MD_BUSY = 1'b1
    } hz_state_t;

endpackage

// File: rtl/pipe_hazard_ctrl_fwd_sel.sv
// Forwarding select for one ALU source operand of the instruction in ID.
// Ports:
//   src, use_src                 - source register number and "operand is read"
//   ex_wn/ex_wreg/ex_m2reg       - destination / write / load flags of EX
//   mem_wn/mem_wreg/mem_m2reg    - destination / write / load flags of MEM
//   sel                          - FWD_* select (purely combinational)
module pipe_fwd_sel
    import pipe_hazard_ctrl_pkg::*;
(
    input  logic [4:0] src,
    input  logic       use_src,
    input  logic [4:0] ex_wn,
    input  logic       ex_wreg,
    input  logic       ex_m2reg,
    input  logic [4:0] mem_wn,
    input  logic       mem_wreg,
    input  logic       mem_m2reg,
    output logic [1:0] sel
);

    always_comb begin
        sel = FWD_REG;
        // r0 is hardwired zero, so it is never forwarded.
        if (use_src && (src != 5'd0)) begin
            // A load in EX has no data yet; it falls through to the MEM check
            // (the load-use stall covers that case).
            if (ex_wreg && (ex_wn == src) && !ex_m2reg) begin
                sel = FWD_EXALU;
            end else if (mem_wreg && (mem_wn == src)) begin
                sel = mem_m2reg ? FWD_MEMLD : FWD_MEMALU;
            end
        end
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard and sequencing controller sitting beside the ID stage.
// Generates operand forwarding selects, stalls IF/ID on load-use hazards and
// while a multi-cycle mul/div occupies EX, and flushes IF/ID on taken branches.
// Ports:
//   clk, clr                 - clock, asynchronous active-high reset
//   IDrs/IDrt/IDusers/IDusert/IDmd/IDbranch - ID instruction info
//   EXwn/EXwreg/EXm2reg, MEMwn/MEMwreg/MEMm2reg - downstream writers
//   IFwpc, IDwir             - PC / IF-ID write enables
//   IFflush, IDbubble        - NOP into IF/ID / NOP controls into ID/EX
//   IDfwda, IDfwdb           - forwarding selects for operands A / B
//   stallCnt                 - saturating count of bubble cycles since reset
module pipe_hazard_ctrl
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int MD_LATENCY = 4,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             clr,
    input  logic [4:0]       IDrs,
    input  logic [4:0]       IDrt,
    input  logic             IDusers,
    input  logic             IDusert,
    input  logic             IDmd,
    input  logic             IDbranch,
    input  logic [4:0]       EXwn,
    input  logic             EXwreg,
    input  logic             EXm2reg,
    input  logic [4:0]       MEMwn,
    input  logic             MEMwreg,
    input  logic             MEMm2reg,
    output logic             IFwpc,
    output logic             IDwir,
    output logic             IFflush,
    output logic             IDbubble,
    output logic [1:0]       IDfwda,
    output logic [1:0]       IDfwdb,
    output logic [CNT_W-1:0] stallCnt
);

    hz_state_t        state_q, state_d;
    logic [4:0]       cnt_q, cnt_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [1:0]       fwda_sel, fwdb_sel;
    logic             luse;

    pipe_fwd_sel u_fwd_a (
        .src      (IDrs),
        .use_src  (IDusers),
        .ex_wn    (EXwn),
        .ex_wreg  (EXwreg),
        .ex_m2reg (EXm2reg),
        .mem_wn   (MEMwn),
        .mem_wreg (MEMwreg),
        .mem_m2reg(MEMm2reg),
        .sel      (fwda_sel)
    );

    pipe_fwd_sel u_fwd_b (
        .src      (IDrt),
        .use_src  (IDusert),
        .ex_wn    (EXwn),
        .ex_wreg  (EXwreg),
        .ex_m2reg (EXm2reg),
        .mem_wn   (MEMwn),
        .mem_wreg (MEMwreg),
        .mem_m2reg(MEMm2reg),
        .sel      (fwdb_sel)
    );

    assign IDfwda = clr ? FWD_REG : fwda_sel;
    assign IDfwdb = clr ? FWD_REG : fwdb_sel;

    // Load in EX feeding an operand read in ID: data arrives one cycle late.
    assign luse = EXwreg && EXm2reg && (EXwn != 5'd0) &&
                  ((IDusers && (EXwn == IDrs)) || (IDusert && (EXwn == IDrt)));

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        IFwpc    = 1'b0;
        IDwir    = 1'b0;
        IDbubble = 1'b1;
        IFflush  = 1'b0;

        case (state_q)
            RUN: begin
                // On a load-use stall the branch outcome is discarded; ID
                // resolves it again once the operand is available.
                if (!luse) begin
                    IFwpc    = 1'b1;
                    IDwir    = 1'b1;
                    IDbubble = 1'b0;
                    IFflush  = IDbranch;
                    if (IDmd && (MD_LATENCY > 1)) begin
                        state_d = MD_BUSY;
                        cnt_d   = 5'(MD_LATENCY - 1);
                    end
                end
            end
            MD_BUSY: begin
                cnt_d = cnt_q - 5'd1;
                if (cnt_q == 5'd1) begin
                    state_d = RUN;
                end
            end
            default: state_d = RUN;
        endcase

        if (clr) begin
            IFwpc    = 1'b0;
            IDwir    = 1'b0;
            IDbubble = 1'b1;
            IFflush  = 1'b0;
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (IDbubble && !clr && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q     <= RUN;
            cnt_q       <= 5'd0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stallCnt = stall_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
module tb_pipe_hazard_ctrl;

    localparam int MD_L  = 4;
    localparam int CW    = 4;   // narrow counter so saturation is reachable
    localparam int SAT   = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          clr = 1'b1;
    logic [4:0]    IDrs = '0, IDrt = '0, EXwn = '0, MEMwn = '0;
    logic          IDusers = 1'b0, IDusert = 1'b0, IDmd = 1'b0, IDbranch = 1'b0;
    logic          EXwreg = 1'b0, EXm2reg = 1'b0, MEMwreg = 1'b0, MEMm2reg = 1'b0;
    logic          IFwpc, IDwir, IFflush, IDbubble;
    logic [1:0]    IDfwda, IDfwdb;
    logic [CW-1:0] stallCnt;
    logic [3:0]    ctl;

    int checks   = 0;
    int failures = 0;
    int exp_stall;

    assign ctl = {IFwpc, IDwir, IDbubble, IFflush};

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(.MD_LATENCY(MD_L), .CNT_W(CW)) dut (
        .clk(clk), .clr(clr),
        .IDrs(IDrs), .IDrt(IDrt), .IDusers(IDusers), .IDusert(IDusert),
        .IDmd(IDmd), .IDbranch(IDbranch),
        .EXwn(EXwn), .EXwreg(EXwreg), .EXm2reg(EXm2reg),
        .MEMwn(MEMwn), .MEMwreg(MEMwreg), .MEMm2reg(MEMm2reg),
        .IFwpc(IFwpc), .IDwir(IDwir), .IFflush(IFflush), .IDbubble(IDbubble),
        .IDfwda(IDfwda), .IDfwdb(IDfwdb), .stallCnt(stallCnt)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        IDrs = 0; IDrt = 0; IDusers = 0; IDusert = 0; IDmd = 0; IDbranch = 0;
        EXwn = 0; EXwreg = 0; EXm2reg = 0; MEMwn = 0; MEMwreg = 0; MEMm2reg = 0;
    endtask

    // Reference forwarding rule for one operand, straight from the priority list.
    function automatic logic [1:0] ref_fwd(input logic [4:0] src, input logic use_src);
        if (!use_src || src == 0) return 2'd0;
        if (EXwreg && EXwn == src && !EXm2reg) return 2'd1;
        if (MEMwreg && MEMwn == src) return MEMm2reg ? 2'd3 : 2'd2;
        return 2'd0;
    endfunction

    task automatic test_reset();
        idle();
        clr = 1; IDmd = 1; IDbranch = 1;
        tick(); tick();
        checks++;
        if (ctl !== 4'b0010) begin failures++; $display("FAIL reset_ctl got=%b exp=%b", ctl, 4'b0010); end
        checks++;
        if (stallCnt !== 0) begin failures++; $display("FAIL reset_cnt got=%0d exp=0", stallCnt); end
        idle();
        clr = 0;
        #1;
        checks++;
        if (ctl !== 4'b1100) begin failures++; $display("FAIL release_ctl got=%b exp=%b", ctl, 4'b1100); end
        checks++;
        if ({IDfwda, IDfwdb} !== 4'b0000) begin failures++; $display("FAIL release_fwd got=%b exp=0000", {IDfwda, IDfwdb}); end
        exp_stall = 0;
        $display("txn reset: ctl=%b stallCnt=%0d", ctl, stallCnt);
        tick();
    endtask

    task automatic test_forward();
        logic [1:0] exp_a [4];
        exp_a[0] = 2'b01; exp_a[1] = 2'b10; exp_a[2] = 2'b11; exp_a[3] = 2'b00;
        for (int k = 0; k < 4; k++) begin
            idle();
            IDrs = 3; IDusers = 1; IDrt = 3; IDusert = 1;
            EXwn = 3; EXwreg = 1; MEMwn = 3; MEMwreg = 1;
            if (k >= 1) EXwreg = 0;
            if (k >= 2) MEMm2reg = 1;
            if (k == 3) begin IDrs = 0; IDrt = 0; end
            #1;
            checks++;
            if (IDfwda !== exp_a[k]) begin failures++; $display("FAIL fwd_a_%0d got=%b exp=%b", k, IDfwda, exp_a[k]); end
            checks++;
            if (IDfwdb !== exp_a[k]) begin failures++; $display("FAIL fwd_b_%0d got=%b exp=%b", k, IDfwdb, exp_a[k]); end
            checks++;
            if (IDbubble !== 1'b0) begin failures++; $display("FAIL fwd_nostall_%0d got=%b exp=0", k, IDbubble); end
            $display("txn forward %0d: fwda=%b fwdb=%b", k, IDfwda, IDfwdb);
        end
        // Operand not read: no forwarding even with a matching writer.
        IDrt = 3; IDusert = 0; EXwreg = 1; MEMm2reg = 0;
        #1;
        checks++;
        if (IDfwdb !== 2'b00) begin failures++; $display("FAIL fwd_unused got=%b exp=00", IDfwdb); end
        idle();
        tick();
    endtask

    task automatic test_load_use();
        idle();
        EXm2reg = 1; EXwreg = 1; EXwn = 5; IDrt = 5; IDusert = 1; IDbranch = 1;
        #1;
        checks++;
        if (ctl !== 4'b0010) begin failures++; $display("FAIL luse_ctl got=%b exp=0010", ctl); end
        tick();
        exp_stall++;
        // Load has moved to MEM; ID now proceeds with load-data forwarding.
        EXm2reg = 0; EXwreg = 0; EXwn = 0; MEMwn = 5; MEMwreg = 1; MEMm2reg = 1;
        #1;
        checks++;
        if (ctl !== 4'b1101) begin failures++; $display("FAIL luse_after_ctl got=%b exp=1101", ctl); end
        checks++;
        if (IDfwdb !== 2'b11) begin failures++; $display("FAIL luse_after_fwd got=%b exp=11", IDfwdb); end
        checks++;
        if (stallCnt !== CW'(exp_stall)) begin failures++; $display("FAIL luse_cnt got=%0d exp=%0d", stallCnt, exp_stall); end
        $display("txn load_use: stallCnt=%0d", stallCnt);
        idle();
        tick();
    endtask

    task automatic test_muldiv();
        idle();
        IDmd = 1;
        #1;
        checks++;
        if (ctl !== 4'b1100) begin failures++; $display("FAIL md_issue_ctl got=%b exp=1100", ctl); end
        for (int i = 0; i < MD_L - 1; i++) begin
            tick();
            IDbranch = 1;   // ignored, as is IDmd, while busy
            #1;
            checks++;
            if (ctl !== 4'b0010) begin failures++; $display("FAIL md_busy_%0d got=%b exp=0010", i, ctl); end
            exp_stall++;
        end
        tick();
        IDmd = 0; IDbranch = 0;
        #1;
        checks++;
        if (ctl !== 4'b1100) begin failures++; $display("FAIL md_return_ctl got=%b exp=1100", ctl); end
        checks++;
        if (stallCnt !== CW'(exp_stall)) begin failures++; $display("FAIL md_cnt got=%0d exp=%0d", stallCnt, exp_stall); end
        $display("txn muldiv: stallCnt=%0d", stallCnt);
        tick();
    endtask

    task automatic test_branch();
        idle();
        IDbranch = 1;
        #1;
        checks++;
        if (ctl !== 4'b1101) begin failures++; $display("FAIL branch_ctl got=%b exp=1101", ctl); end
        tick();
        IDbranch = 0;
        #1;
        checks++;
        if (ctl !== 4'b1100) begin failures++; $display("FAIL branch_after got=%b exp=1100", ctl); end
        $display("txn branch: ctl=%b", ctl);
        tick();
    endtask

    task automatic test_reset_mid_busy();
        idle();
        IDmd = 1;
        tick();
        IDmd = 0;
        tick();
        checks++;
        if (IDbubble !== 1'b1) begin failures++; $display("FAIL midrst_busy got=%b exp=1", IDbubble); end
        clr = 1;
        #1;
        checks++;
        if (stallCnt !== 0) begin failures++; $display("FAIL midrst_cnt got=%0d exp=0", stallCnt); end
        tick();
        clr = 0;
        exp_stall = 0;
        for (int i = 0; i < MD_L; i++) begin
            #1;
            checks++;
            if (ctl !== 4'b1100) begin failures++; $display("FAIL midrst_run_%0d got=%b exp=1100", i, ctl); end
            tick();
        end
        checks++;
        if (stallCnt !== 0) begin failures++; $display("FAIL midrst_nostall got=%0d exp=0", stallCnt); end
        $display("txn reset_mid_busy: stallCnt=%0d", stallCnt);
    endtask

    task automatic test_saturate();
        idle();
        EXm2reg = 1; EXwreg = 1; EXwn = 7; IDrs = 7; IDusers = 1;
        for (int i = 1; i <= SAT + 4; i++) begin
            tick();
            exp_stall = (i < SAT) ? i : SAT;
            checks++;
            if (stallCnt !== CW'(exp_stall)) begin failures++; $display("FAIL sat_%0d got=%0d exp=%0d", i, stallCnt, exp_stall); end
        end
        $display("txn saturate: stallCnt=%0d", stallCnt);
        idle();
        clr = 1; tick(); clr = 0;
    endtask

    task automatic test_random();
        int         busy_left = 0;
        logic       luse, stall;
        logic [3:0] exp_ctl;
        logic [1:0] ea, eb;
        exp_stall = 0;
        for (int n = 0; n < 300; n++) begin
            clr      = ($urandom_range(0, 39) == 0);
            IDrs     = 5'($urandom_range(0, 3));
            IDrt     = 5'($urandom_range(0, 3));
            IDusers  = 1'($urandom);
            IDusert  = 1'($urandom);
            IDmd     = ($urandom_range(0, 5) == 0);
            IDbranch = 1'($urandom);
            EXwn     = 5'($urandom_range(0, 3));
            EXwreg   = 1'($urandom);
            EXm2reg  = 1'($urandom);
            MEMwn    = 5'($urandom_range(0, 3));
            MEMwreg  = 1'($urandom);
            MEMm2reg = 1'($urandom);
            #1;
            if (clr) begin
                busy_left = 0;
                exp_stall = 0;
            end
            luse = EXwreg && EXm2reg && EXwn != 0 &&
                   ((IDusers && EXwn == IDrs) || (IDusert && EXwn == IDrt));
            stall = clr || busy_left > 0 || luse;
            exp_ctl = stall ? 4'b0010 : {2'b11, 1'b0, IDbranch};
            ea = clr ? 2'd0 : ref_fwd(IDrs, IDusers);
            eb = clr ? 2'd0 : ref_fwd(IDrt, IDusert);
            checks++;
            if (ctl !== exp_ctl) begin failures++; $display("FAIL rnd_ctl_%0d got=%b exp=%b", n, ctl, exp_ctl); end
            checks++;
            if (IDfwda !== ea) begin failures++; $display("FAIL rnd_fwda_%0d got=%b exp=%b", n, IDfwda, ea); end
            checks++;
            if (IDfwdb !== eb) begin failures++; $display("FAIL rnd_fwdb_%0d got=%b exp=%b", n, IDfwdb, eb); end
            checks++;
            if (stallCnt !== CW'(exp_stall)) begin failures++; $display("FAIL rnd_cnt_%0d got=%0d exp=%0d", n, stallCnt, exp_stall); end
            $display("txn rnd %0d: clr=%b md=%b luse=%b busy=%0d ctl=%b cnt=%0d", n, clr, IDmd, luse, busy_left, ctl, stallCnt);
            if (!clr) begin
                if (stall && exp_stall < SAT) exp_stall++;
                if (busy_left > 0) busy_left--;
                else if (!luse && IDmd && MD_L > 1) busy_left = MD_L - 1;
            end
            tick();
        end
        clr = 0;
    endtask

    initial begin
        test_reset();
        test_forward();
        test_load_use();
        test_muldiv();
        test_branch();
        test_reset_mid_busy();
        test_saturate();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
Hazard and sequencing controller for the 5-stage pipeline. It sits beside the ID stage and generates the ALU operand-forwarding selects for the instruction in ID. It also stalls IF/ID on load-use hazards and while a multi-cycle mul/div occupies EX, and flushes IF/ID on a taken branch. It is the control block that turns the no-hazard ID stage into a hazard-safe pipeline.

Parameters:
MD_LATENCY, 4, EX cycles of a mul/div op (legal 1..16); the op causes MD_LATENCY-1 stall cycles.
CNT_W, 16, width of the stall-statistics counter.

Ports:
clk  in  1  pipeline clock, rising edge
clr  in  1  asynchronous active-high reset
IDrs  in  5  rs field of the instruction in ID
IDrt  in  5  rt field of the instruction in ID
IDusers  in  1  ID instruction reads rs
IDusert  in  1  ID instruction reads rt
IDmd  in  1  ID instruction is a multi-cycle mul/div
IDbranch  in  1  ID resolved a taken branch/jump this cycle
EXwn  in  5  destination register in EX
EXwreg  in  1  EX instruction writes the register file
EXm2reg  in  1  EX instruction is a load
MEMwn  in  5  destination register in MEM
MEMwreg  in  1  MEM instruction writes the register file
MEMm2reg  in  1  MEM instruction is a load
IFwpc  out  1  PC write enable
IDwir  out  1  IF/ID register write enable
IFflush  out  1  load NOP into IF/ID on the next edge
IDbubble  out  1  force NOP controls into ID/EX on the next edge
IDfwda  out  2  operand A select: 00 regfile, 01 EX ALU result, 10 MEM ALU result, 11 MEM load data
IDfwdb  out  2  operand B select, same encoding
stallCnt  out  CNT_W  saturating count of stall cycles since reset

Behaviour:
- Reset (clr=1, asynchronous): state=RUN, cnt=0, stallCnt=0.
- While clr is high, outputs are forced to IFwpc=0, IDwir=0, IDbubble=1, IFflush=0, IDfwda=IDfwdb=00.
- Forwarding is combinational, with zero latency and no dependence on state.
  - Forwarding never occurs for register 0, or when IDusers/IDusert is 0.
  - EX match (EXwreg, EXwn==src, EXm2reg=0) gives 01.
  - Otherwise, a MEM match with MEMwreg gives 11 if MEMm2reg=1, else 10.
  - Otherwise the select is 00.
  - When EX and MEM both match, EX wins.
- Load-use hazard, combinational: luse = EXwreg & EXm2reg & EXwn!=0 & ((IDusers & EXwn==IDrs) | (IDusert & EXwn==IDrt)).
- FSM states: RUN, MD_BUSY.
- RUN:
  - If luse: IFwpc=0, IDwir=0, IDbubble=1, IFflush=0. IDbranch is ignored this cycle; ID re-resolves after the stall.
  - Else: IFwpc=1, IDwir=1, IDbubble=0, IFflush=IDbranch.
  - If IDmd=1 and MD_LATENCY>1 (and no luse), the next state is MD_BUSY with cnt=MD_LATENCY-1.
- MD_BUSY:
  - Outputs: IFwpc=0, IDwir=0, IDbubble=1, IFflush=0.
  - cnt decrements each cycle. When cnt==1, the next state is RUN.
  - Result: exactly MD_LATENCY-1 busy cycles. An IDmd seen during busy is ignored; it is re-evaluated in RUN.
- stallCnt increments on every cycle where IDbubble=1 and clr=0, and saturates at all-ones.
- Reset mid-MD_BUSY aborts to RUN immediately; no residual stall.
- With MD_LATENCY=1, MD_BUSY is never entered.

Decomposition:
- Shared package: forwarding-select constants FWD_REG/FWD_EXALU/FWD_MEMALU/FWD_MEMLD and state encodings RUN/MD_BUSY.
- One sub-module, pipe_fwd_sel: combinational select for one operand, instantiated twice (rs, rt).
- FSM, counters and stall logic stay in the top.

Test Plan:
- Reset: clr=1 with IDmd=1 -> IFwpc=0, IDbubble=1, stallCnt=0. After release, with idle inputs -> IFwpc=1, IDwir=1, fwd=00.
- Forward priority: IDrs=3, IDusers=1, EXwn=3/EXwreg=1, MEMwn=3/MEMwreg=1 -> IDfwda=01. With EXwreg=0 -> 10. With MEMm2reg=1 -> 11. With IDrs=0 -> 00.
- Load-use: EXm2reg=1, EXwreg=1, EXwn=5, IDrt=5, IDusert=1, IDbranch=1 -> one cycle of IFwpc=0, IDbubble=1, IFflush=0; stallCnt increments by 1.
- Mul/div with MD_LATENCY=4: IDmd=1 in RUN -> that cycle IFwpc=1; the next 3 cycles IFwpc=0, IDbubble=1; back to RUN on the 4th; stallCnt=3.
- Branch: IDbranch=1, no hazard -> IFflush=1, IFwpc=1 for one cycle.
- Reset asserted on the 2nd MD_BUSY cycle -> state RUN immediately. After release, no further stall cycles.
